// File: rtl/tpu_host_if_if.sv
// tpu_host_if_if: bundle of the host byte streams and the core-side operand,
// launch and result signals for tpu_host_if.
//   rx_*        host -> block command/payload bytes (valid/ready)
//   tx_*        block -> host result bytes (valid/ready)
//   mat_a/mat_b flat operand matrices, row-major, element 0 at LSBs
//   start       one-cycle launch pulse; core_done/core_result from the core
//   busy/err    status
// Modports: slave = the host interface block, master = its environment.
interface tpu_host_if_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 16
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [N*N*DW-1:0]   mat_a;
    logic [N*N*DW-1:0]   mat_b;
    logic                start;
    logic                core_done;
    logic [N*N*AW-1:0]   core_result;
    logic                busy;
    logic                err;

    modport slave (
        input  rx_data, rx_valid, tx_ready, core_done, core_result,
        output rx_ready, tx_data, tx_valid, mat_a, mat_b, start, busy, err
    );

    modport master (
        output rx_data, rx_valid, tx_ready, core_done, core_result,
        input  rx_ready, tx_data, tx_valid, mat_a, mat_b, start, busy, err
    );
endinterface

// File: rtl/tpu_host_if.sv
// tpu_host_if: byte-stream host front end for an NxN systolic matmul core.
// Decodes command bytes (opcode = rx_data[7:6]: NOP, LOAD_A, LOAD_B, RUN),
// assembles A/B byte-by-byte, pulses start, captures core_result on
// core_done and streams it back LSB byte first.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  tpu_host_if_if.slave (rx/tx streams, operands, start/done, status)
// Optional feature: define TPU_HOST_TIMEOUT_EN to add a WAIT-state watchdog
// of TIMEOUT_CYC cycles that sets the sticky err flag and aborts the run.
module tpu_host_if #(
    parameter int N           = 2,
    parameter int DW          = 8,
    parameter int AW          = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,
    tpu_host_if_if.slave  bus
);
    localparam int LD_BYTES = N * N * DW / 8;
    localparam int TX_BYTES = N * N * AW / 8;
    localparam int MAXB     = (LD_BYTES > TX_BYTES) ? LD_BYTES : TX_BYTES;
    localparam int CW       = $clog2(MAXB);
    localparam int LIW      = $clog2(LD_BYTES);
    localparam int SIW      = $clog2(TX_BYTES);

    if (!(DW == 8 || DW == 16) || (AW % 8) != 0 || AW > 32 || N < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("tpu_host_if: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SEND} state_t;

    state_t                     state, state_n;
    logic                       tgt_b;
    logic [CW-1:0]              cnt;
    logic [LD_BYTES-1:0][7:0]   mat_a_q, mat_b_q;
    logic [TX_BYTES-1:0][7:0]   res_q;
    logic                       rx_fire, tx_fire, last_ld, last_tx, timeout;

    assign rx_fire = bus.rx_valid && bus.rx_ready;
    assign tx_fire = bus.tx_valid && bus.tx_ready;
    assign last_ld = (cnt == CW'(LD_BYTES - 1));
    assign last_tx = (cnt == CW'(TX_BYTES - 1));
    assign bus.mat_a = mat_a_q;
    assign bus.mat_b = mat_b_q;

`ifdef TPU_HOST_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wdog;
    logic          err_q;

    // wdog holds the number of completed WAIT cycles; the limit is hit on the
    // TIMEOUT_CYC-th cycle, where a simultaneous core_done still wins.
    assign timeout = (state == WAIT) && (wdog == WW'(TIMEOUT_CYC - 1)) && !bus.core_done;
    assign bus.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == START)     wdog  <= '0;
            else if (state == WAIT) wdog  <= wdog + 1'b1;
            if (timeout)            err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        bus.rx_ready = 1'b0;
        bus.start    = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.busy     = (state != IDLE);
        case (state)
            IDLE: begin
                bus.rx_ready = 1'b1;
                if (rx_fire) begin
                    case (bus.rx_data[7:6])
                        2'b01, 2'b10: state_n = LOAD;
                        2'b11:        state_n = START;
                        default:      state_n = IDLE;
                    endcase
                end
            end
            LOAD: begin
                bus.rx_ready = 1'b1;
                if (rx_fire && last_ld) state_n = IDLE;
            end
            START: begin
                bus.start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (bus.core_done) state_n = SEND;
                else if (timeout)  state_n = IDLE;
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = res_q[cnt[SIW-1:0]];
                if (tx_fire && last_tx) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tgt_b   <= 1'b0;
            cnt     <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            res_q   <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (rx_fire) tgt_b <= (bus.rx_data[7:6] == 2'b10);
                LOAD: if (rx_fire) begin
                    if (tgt_b) mat_b_q[cnt[LIW-1:0]] <= bus.rx_data;
                    else       mat_a_q[cnt[LIW-1:0]] <= bus.rx_data;
                    cnt <= last_ld ? '0 : cnt + 1'b1;
                end
                WAIT: if (bus.core_done) begin
                    res_q <= bus.core_result;
                    cnt   <= '0;
                end
                SEND: if (tx_fire) cnt <= last_tx ? '0 : cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_host_if.sv
// Directed bench for tpu_host_if (N=2, DW=8, AW=16, TIMEOUT_CYC=16).
module tb_tpu_host_if;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tpu_host_if_if #(.N(2), .DW(8), .AW(16)) bus ();
    tpu_host_if #(.N(2), .DW(8), .AW(16), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_tx [8] = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte at a negedge; it is accepted at the following posedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    // RUN, expect a single start pulse, answer with core_done 3 cycles later.
    // Returns at the first negedge of SEND.
    task automatic run_cmd();
        int starts;
        send_byte(8'hC0);
        @(negedge clk);
        chk("start_pulse", bus.start, 1'b1);
        chk("rx_ready_start", bus.rx_ready, 1'b0);
        starts = 1;
        repeat (3) begin
            @(negedge clk);
            if (bus.start) starts++;
        end
        chk("tx_valid_wait", bus.tx_valid, 1'b0);
        bus.core_done = 1'b1;
        @(posedge clk);
        #1 bus.core_done = 1'b0;
        @(negedge clk);
        chk("start_count", starts, 1);
    endtask

    // Read out all result bytes; optional 5-cycle stall before byte bp_at.
    task automatic drain(input int bp_at);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_valid[%0d]", i), bus.tx_valid, 1'b1);
            chk($sformatf("tx_data[%0d]", i), bus.tx_data, exp_tx[i]);
            chk($sformatf("rx_ready_send[%0d]", i), bus.rx_ready, 1'b0);
            if (i == bp_at) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", bus.tx_valid, 1'b1);
                    chk("bp_data", bus.tx_data, exp_tx[i]);
                end
            end
            bus.tx_ready = 1'b1;
            @(posedge clk);
            #1 bus.tx_ready = 1'b0;
            @(negedge clk);
        end
        chk("tx_valid_done", bus.tx_valid, 1'b0);
        chk("busy_done", bus.busy, 1'b0);
        chk("rx_ready_done", bus.rx_ready, 1'b1);
    endtask

    initial begin
        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        bus.tx_ready    = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_result = '1;

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", bus.rx_ready, 1'b1);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_start", bus.start, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_mat_a", bus.mat_a, 32'h0);
        chk("rst_mat_b", bus.mat_b, 32'h0);

        // LOAD_A
        send_byte(8'h40);
        @(negedge clk);
        chk("busy_load", bus.busy, 1'b1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        @(negedge clk);
        chk("mat_a_load", bus.mat_a, 32'h04030201);
        chk("mat_b_untouched", bus.mat_b, 32'h0);
        chk("busy_after_load", bus.busy, 1'b0);

        // spurious done in IDLE
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
        @(negedge clk);
        chk("spur_idle_txv", bus.tx_valid, 1'b0);
        chk("spur_idle_busy", bus.busy, 1'b0);

        // LOAD_B with a spurious done mid-payload
        send_byte(8'h80); send_byte(8'h05); send_byte(8'h06);
        @(negedge clk);
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("spur_load_txv", bus.tx_valid, 1'b0);
        chk("spur_load_busy", bus.busy, 1'b1);
        send_byte(8'h07); send_byte(8'h08);
        @(negedge clk);
        chk("mat_b_load", bus.mat_b, 32'h08070605);
        chk("mat_a_kept", bus.mat_a, 32'h04030201);

        // NOP with don't-care low bits
        send_byte(8'h3F);
        @(negedge clk);
        chk("nop_busy", bus.busy, 1'b0);
        chk("nop_mat_a", bus.mat_a, 32'h04030201);

        // RUN + readback with backpressure before byte 3
        bus.core_result = {16'h0032, 16'h002B, 16'h0016, 16'h0013};
        run_cmd();
        drain(3);

        // reset mid-load
        send_byte(8'h40); send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_mat_a", bus.mat_a, 32'h0);
        chk("midrst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_mat_b", bus.mat_b, 32'h0);
        send_byte(8'h40);
        @(negedge clk);
        chk("cmd_after_rst", bus.busy, 1'b1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        chk("reload_mat_a", bus.mat_a, 32'h44332211);
        chk("reload_busy", bus.busy, 1'b0);

`ifdef TPU_HOST_TIMEOUT_EN
        // watchdog: 16 WAIT cycles without core_done
        send_byte(8'hC0);
        @(negedge clk);
        chk("to_start", bus.start, 1'b1);
        repeat (16) @(negedge clk);
        chk("to_err_edge", bus.err, 1'b0);
        chk("to_busy_edge", bus.busy, 1'b1);
        @(negedge clk);
        chk("to_err", bus.err, 1'b1);
        chk("to_idle", bus.busy, 1'b0);
        chk("to_no_tx", bus.tx_valid, 1'b0);
        run_cmd();
        drain(-1);
        chk("to_err_sticky", bus.err, 1'b1);
`else
        // without the watchdog WAIT holds indefinitely
        send_byte(8'hC0);
        repeat (40) @(negedge clk);
        chk("nowd_busy", bus.busy, 1'b1);
        chk("nowd_err", bus.err, 1'b0);
        chk("nowd_txv", bus.tx_valid, 1'b0);
        bus.core_done = 1'b1;
        @(posedge clk);
        #1 bus.core_done = 1'b0;
        @(negedge clk);
        drain(-1);
        chk("nowd_err_end", bus.err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
